// File: rtl/shift_seq_ctrl.sv
// Purpose: sequences one load strobe, then WIDTH shift strobes spaced GAP cycles apart, into an external left-shift register.
// Latency: load 1 cycle after accept, shift k at accept+2+k*(GAP+1), done 1 cycle after the last shift.
// Backpressure: in_ready is high only in IDLE, so words are accepted one at a time; abort returns to IDLE on the next cycle.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  input  logic [WIDTH-1:0] sr_q,
  output logic             sr_load,
  output logic             sr_shift,
  output logic [WIDTH-1:0] sr_data,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);
  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);
  localparam logic [3:0]    GAP_LEN  = 4'(GAP);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_cnt_inc;
  logic [3:0]    gap_cnt;
  logic [3:0]    gap_cnt_inc;
  logic          sr_q_unused;

  assign bit_cnt_inc = bit_cnt + CW'(1);
  assign gap_cnt_inc = gap_cnt + 4'd1;

  // Gated by rst so the producer never sees ready while the block is held in reset.
  assign in_ready = (state == S_IDLE) && !rst;

  // Only the MSB of the register leaves the device; the lower bits are observed for nothing.
  assign ser_bit     = ser_valid & sr_q[WIDTH-1];
  assign sr_q_unused = ^sr_q[WIDTH-2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      sr_data   <= '0;
      sr_load   <= 1'b0;
      sr_shift  <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sr_load   <= 1'b0;
      sr_shift  <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sr_data <= in_data;
            bit_cnt <= '0;
            state   <= S_LOAD;
            sr_load <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state     <= S_SHIFT;
            sr_shift  <= 1'b1;
            ser_valid <= 1'b1;
          end
        end
        S_SHIFT: begin
          bit_cnt <= bit_cnt_inc;
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (bit_cnt_inc == LAST_BIT) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (GAP > 0) begin
            state   <= S_GAP;
            gap_cnt <= '0;
          end else begin
            sr_shift  <= 1'b1;
            ser_valid <= 1'b1;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt_inc;
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (gap_cnt_inc == GAP_LEN) begin
            state     <= S_SHIFT;
            sr_shift  <= 1'b1;
            ser_valid <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: two instances (GAP=0 and GAP=2) each drive a behavioural shift register.
// A per-instance model schedules the expected strobes on accept, and a negedge monitor consumes them.
module tb_shift_seq_ctrl;
  localparam int W = 4;

  typedef enum int {EV_LOAD, EV_SHIFT, EV_DONE} ev_kind_t;
  typedef struct {
    int       cyc;
    ev_kind_t kind;
    logic     b;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   in_valid = '0;
  logic [1:0]   abort = '0;
  logic [W-1:0] in_data [2];
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;
  bit           end_chk = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int G = 2 * g;

    logic         in_ready, sr_load, sr_shift, ser_bit, ser_valid, busy, done;
    logic [W-1:0] sr_data;
    logic [W-1:0] sr_q = '0;
    ev_t          q[$];
    int           free_at = 0;
    int           acc_t = -100;
    int           done_c = -100;
    int           acc_cnt = 0;
    logic [W-1:0] last_word = '0;
    bit           ended = 1'b0;

    shift_seq_ctrl #(.WIDTH(W), .GAP(G)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_data   (in_data[g]),
      .in_ready  (in_ready),
      .abort     (abort[g]),
      .sr_q      (sr_q),
      .sr_load   (sr_load),
      .sr_shift  (sr_shift),
      .sr_data   (sr_data),
      .ser_bit   (ser_bit),
      .ser_valid (ser_valid),
      .busy      (busy),
      .done      (done)
    );

    // Plain parallel-load, left-shift, zero-fill register.
    always @(posedge clk) begin
      if (sr_load) sr_q <= sr_data;
      else if (sr_shift) sr_q <= {sr_q[W-2:0], 1'b0};
    end

    // Reference model: cyc here is the cycle being closed by this edge.
    always @(posedge clk) begin
      ev_t e;
      if (rst) begin
        free_at = cyc + 1;
        while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
        last_word = '0;
        acc_t = -100;
        done_c = -100;
      end else begin
        if (abort[g] && cyc > acc_t && cyc < done_c && cyc < free_at) begin
          free_at = cyc + 1;
          while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
        end
        if (in_valid[g] && cyc >= free_at) begin
          last_word = in_data[g];
          acc_t = cyc;
          e.cyc = cyc + 1; e.kind = EV_LOAD; e.b = 1'b0;
          q.push_back(e);
          for (int k = 0; k < W; k++) begin
            e.cyc = cyc + 2 + k * (G + 1);
            e.kind = EV_SHIFT;
            e.b = in_data[g][W-1-k];
            q.push_back(e);
          end
          done_c = cyc + 2 + (W - 1) * (G + 1) + 1;
          e.cyc = done_c; e.kind = EV_DONE; e.b = 1'b0;
          q.push_back(e);
          free_at = done_c + 1;
          acc_cnt++;
        end
      end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL %s inst%0d cyc %0d: got %0h, expected %0h", nm, g, cyc, act, exp);
      end
    endtask

    always @(negedge clk) begin
      bit  hit;
      ev_t e;
      if (cyc >= 1) begin
        hit = (q.size() > 0) && (q[0].cyc == cyc);
        e.cyc = 0; e.kind = EV_DONE; e.b = 1'b0;
        if (hit) e = q.pop_front();
        chk("in_ready", in_ready, !rst && cyc >= free_at);
        chk("busy", busy, cyc < free_at);
        chk("sr_data", sr_data, last_word);
        chk("sr_load", sr_load, hit && e.kind == EV_LOAD);
        chk("sr_shift", sr_shift, hit && e.kind == EV_SHIFT);
        chk("ser_valid", ser_valid, hit && e.kind == EV_SHIFT);
        chk("ser_bit", ser_bit, (hit && e.kind == EV_SHIFT) ? e.b : 1'b0);
        chk("done", done, hit && e.kind == EV_DONE);
        if (end_chk && !ended) begin
          ended = 1'b1;
          chk("pending_events", q.size(), 0);
        end
      end
    end
  end

  function automatic int acc_count(input int g);
    return (g != 0) ? gi[1].acc_cnt : gi[0].acc_cnt;
  endfunction

  function automatic int acc_cycle(input int g);
    return (g != 0) ? gi[1].acc_t : gi[0].acc_t;
  endfunction

  function automatic int free_cycle(input int g);
    return (g != 0) ? gi[1].free_at : gi[0].free_at;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int g, input logic [W-1:0] w);
    int a0;
    int n;
    a0 = acc_count(g);
    in_valid[g] = 1'b1;
    in_data[g] = w;
    n = 0;
    while (acc_count(g) == a0) begin
      step();
      n++;
      if (n > 200) begin
        $display("FAIL send_timeout inst%0d: no accept within 200 cycles", g);
        $fatal(1, "send timeout");
      end
    end
    in_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while (cyc < free_cycle(g)) begin
      step();
      n++;
      if (n > 500) begin
        $display("FAIL idle_timeout inst%0d: still busy after 500 cycles", g);
        $fatal(1, "idle timeout");
      end
    end
  endtask

  initial begin
    int t;
    in_data[0] = '0;
    in_data[1] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(0, 4'b1011);
    wait_idle(0);
    send(1, 4'b0110);
    wait_idle(1);

    // Abort in the second gap cycle after shift 1, then a new word right away.
    send(1, 4'b1101);
    t = acc_cycle(1);
    while (cyc < t + 7) step();
    abort[1] = 1'b1;
    step();
    abort[1] = 1'b0;
    send(1, 4'b1001);
    wait_idle(1);

    // in_valid held high with in_data changing every cycle.
    in_valid[0] = 1'b1;
    repeat (40) begin
      in_data[0] = 4'($urandom);
      step();
    end
    in_valid[0] = 1'b0;
    wait_idle(0);

    // Reset during shift 2.
    send(0, 4'b1110);
    t = acc_cycle(0);
    while (cyc < t + 4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();

    repeat (600) begin
      for (int g = 0; g < 2; g++) begin
        in_valid[g] = 1'($urandom_range(0, 1));
        in_data[g] = 4'($urandom);
        abort[g] = ($urandom_range(0, 11) == 0);
      end
      step();
    end
    in_valid = '0;
    abort = '0;
    wait_idle(0);
    wait_idle(1);
    repeat (2) step();

    end_chk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller for the team's parallel-load, left-shift register (load/shift/data_in/data_out interface). Accepts a parallel word over a valid/ready handshake, drives one load pulse followed by exactly WIDTH shift pulses with programmable spacing, and presents each bit shifted out of the MSB as a qualified serial stream. It sits between a word producer and the shift register, which stays a plain datapath with no sequencing of its own.

## Interface
- WIDTH, 4: shift register width in bits; legal range 2..32.
- GAP, 0: idle cycles inserted between successive shift pulses; legal range 0..15.

- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  WIDTH  word to serialize.
- in_ready  output  1  controller can accept a word; high only in IDLE and when rst is low.
- abort  input  1  cancel the transfer in progress.
- sr_q  input  WIDTH  current contents of the shift register (its data_out).
- sr_load  output  1  load strobe to the shift register.
- sr_shift  output  1  shift-left strobe to the shift register.
- sr_data  output  WIDTH  registered copy of the accepted word; drives the register's data_in.
- ser_bit  output  1  equals sr_q[WIDTH-1] while ser_valid is high, otherwise 0.
- ser_valid  output  1  high in exactly the cycles where sr_shift is high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last shift of a completed transfer.

## Operation
- States: IDLE, LOAD, SHIFT, GAP, DONE.
  - IDLE: in_ready=1. When in_valid is high, capture in_data into sr_data, clear bit_cnt, and go to LOAD.
  - LOAD: sr_load=1 for one cycle, then go to SHIFT.
  - SHIFT: sr_shift=1, ser_valid=1, and bit_cnt increments.
    - If bit_cnt reaches WIDTH, go to DONE.
    - Otherwise, if GAP>0, go to GAP with gap_cnt cleared.
    - Otherwise, stay in SHIFT.
  - GAP: all strobes are low and gap_cnt increments. When gap_cnt reaches GAP, go to SHIFT.
  - DONE: done=1 for one cycle, then go to IDLE.
- Outputs are Moore outputs of the current state. sr_load, sr_shift, ser_valid, done, busy and in_ready have no combinational path from in_valid or abort.
- abort, sampled high in LOAD, SHIFT or GAP: next state is IDLE and no done pulse is issued. The strobe of the abort cycle itself still fires. abort is ignored in IDLE and DONE.
- in_valid is ignored outside IDLE. A word is accepted only on the cycle in_valid and in_ready are both high.
- sr_data holds its value until the next accept. It is not cleared by done or abort.
- bit_cnt is $clog2(WIDTH+1) bits wide and gap_cnt is 4 bits wide. Neither counter wraps: each is compared for equality and cleared on entry to its state.
- Reset: state=IDLE and bit_cnt=gap_cnt=0. Also sr_data=0, sr_load=sr_shift=ser_valid=ser_bit=done=busy=0. in_ready=0 while rst is high and 1 on the first cycle after rst falls.

## Timing
- Accept occurs at cycle T.
  - LOAD is at T+1. The register captures at the end of T+1.
  - Shift k (k=0..WIDTH-1) is at T+2+k*(GAP+1).
  - done follows the last shift by one cycle.
  - in_ready rises one cycle after done.
- Total occupancy from accept to the next in_ready is WIDTH*(GAP+1)-GAP+3 cycles.
- ser_bit in shift k equals bit WIDTH-1-k of the accepted word, provided the register shifts left and fills with 0.
- Back-to-back throughput: one word per WIDTH*(GAP+1)-GAP+3 cycles. There is no overlap of consecutive transfers.
- When abort is sampled at cycle A, the controller is in IDLE at A+1, with in_ready=1 (rst low) and busy=0.

## Test plan
- Reset: hold rst for 2 cycles, then release. Required response: all outputs are 0 during reset, in_ready=1 on the first cycle after release, and sr_data=0.
- Basic transfer (WIDTH=4, GAP=0), in_data=4'b1011 accepted at T:
  - sr_load is high at T+1.
  - sr_shift and ser_valid are high at T+2..T+5, with ser_bit=1,0,1,1.
  - done is high at T+6 and in_ready is high at T+7.
- Spaced shifts (GAP=2), in_data=4'b0110:
  - shifts occur at T+2, T+5, T+8, T+11 with ser_bit=0,1,1,0.
  - strobes are low in every GAP cycle.
  - done is high at T+12.
- Abort in the second GAP cycle after shift 1 (GAP=2): no further sr_shift, no done, busy=0 on the next cycle, and a new word is accepted immediately afterwards.
- Handshake: hold in_valid high continuously with changing in_data. Required response: only the words present on accept cycles are serialized, and in_data changes between accepts have no effect on sr_data.
- Reset mid-transfer: assert rst during shift 2. Required response: IDLE on the next cycle, no done pulse, and all outputs at their reset values.
